// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial subtractor. One full_subtractor cell is time-shared across the
// operand bits, LSB first, with the borrow carried in a register between bits.
// Optional feature macro: SUB_BORROW_IN_EN adds the 'bin' initial-borrow port.
// Without the macro the initial borrow is constant 0.
`timescale 1ns/1ps

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic dout,
   output logic bout
);
   assign dout = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SUB_BORROW_IN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opa_s;
   logic [WIDTH-1:0] opb_r;
   logic [WIDTH-1:0] opb_s;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] res_s;
   logic             brw_r;
   logic             brw_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_s;
   logic             load_result_s;
   logic             init_borrow_s;
   logic             cell_dout_s;
   logic             cell_bout_s;

`ifdef SUB_BORROW_IN_EN
   assign init_borrow_s = bin;
`else
   assign init_borrow_s = 1'b0;
`endif

   // The single shared one-bit datapath cell
   full_subtractor u_cell (
      .a    (opa_r[0]),
      .b    (opb_r[0]),
      .bin  (brw_r),
      .dout (cell_dout_s),
      .bout (cell_bout_s)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         opa_r   <= '0;
         opb_r   <= '0;
         res_r   <= '0;
         brw_r   <= 1'b0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         opa_r   <= opa_s;
         opb_r   <= opb_s;
         res_r   <= res_s;
         brw_r   <= brw_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state and per-bit sequencing
   always_comb begin
      state_s       = state_r;
      opa_s         = opa_r;
      opb_s         = opb_r;
      res_s         = res_r;
      brw_s         = brw_r;
      cnt_s         = cnt_r;
      load_result_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_RUN;
               opa_s   = a;
               opb_s   = b;
               brw_s   = init_borrow_s;
               cnt_s   = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Consume bit 0, build the result from the top down so the
            // first (LSB) result bit lands at bit 0 after WIDTH shifts.
            opa_s = {1'b0, opa_r[WIDTH-1:1]};
            opb_s = {1'b0, opb_r[WIDTH-1:1]};
            res_s = {cell_dout_s, res_r[WIDTH-1:1]};
            brw_s = cell_bout_s;
            if (cnt_r == LAST_BIT) begin
               state_s       = ST_DONE;
               load_result_s = 1'b1;
            end else begin
               state_s = ST_RUN;
               cnt_s   = cnt_r + CW'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Registered status and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         busy <= (state_s != ST_IDLE);
         done <= (state_s == ST_DONE);
         if (load_result_s) begin
            diff       <= res_s;
            borrow_out <= cell_bout_s;
         end else begin
            diff       <= diff;
            borrow_out <= borrow_out;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed testbench for serial_subtractor_ctrl (WIDTH=8 plus an exhaustive
// WIDTH=4 instance). Borrow-in vectors are built only with SUB_BORROW_IN_EN.
`timescale 1ns/1ps

module tb_serial_subtractor_ctrl;

   logic       clk;
   logic       rst_n;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       bin8;
   logic       busy8;
   logic       done8;
   logic [7:0] diff8;
   logic       bo8;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       bin4;
   logic       busy4;
   logic       done4;
   logic [3:0] diff4;
   logic       bo4;

   int n_assert;
   int n_fail;

   serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start8),
      .a          (a8),
      .b          (b8),
`ifdef SUB_BORROW_IN_EN
      .bin        (bin8),
`endif
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (bo8)
   );

   serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start4),
      .a          (a4),
      .b          (b4),
`ifdef SUB_BORROW_IN_EN
      .bin        (bin4),
`endif
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
      .borrow_out (bo4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One WIDTH=8 operation; returns latency (edges after accept until done)
   // and the number of sampled cycles with busy high.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output int lat, output int bcnt);
      @(negedge clk);
      start8 = 1'b1; a8 = ia; b8 = ib; bin8 = ibin;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'b1;
      lat = 0; bcnt = 0;
      while (done8 !== 1'b1 && lat < 20) begin
         if (busy8 === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy8 === 1'b1) bcnt++;
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done8}, 32'd0);
      chk("busy_fall", {31'd0, busy8}, 32'd0);
   endtask

   initial begin
      int lat;
      int bcnt;
      int ndone;
      int first_done;
      n_assert = 0; n_fail = 0;
      rst_n = 1'b0;
      start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;
      start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_done", {31'd0, done8}, 32'd0);
      chk("rst_diff", {24'd0, diff8}, 32'd0);
      chk("rst_borrow", {31'd0, bo8}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // 200 - 55
      run8(8'd200, 8'd55, 1'b0, lat, bcnt);
      chk("lat_200_55", lat, 32'd8);
      chk("busy_cycles", bcnt, 32'd9);
      chk("diff_200_55", {24'd0, diff8}, 32'd145);
      chk("bo_200_55", {31'd0, bo8}, 32'd0);

      // 9 - 3 with start held high through RUN and DONE
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd9; b8 = 8'd3; bin8 = 1'b0;
      @(posedge clk); #1;
      a8 = 8'd1; b8 = 8'd1;
      ndone = 0; first_done = 0;
      for (int i = 1; i <= 18; i++) begin
         @(posedge clk); #1;
         if (done8 === 1'b1) begin
            ndone++;
            if (first_done == 0) first_done = i;
         end
         if (i == 8) chk("held_diff_9_3", {24'd0, diff8}, 32'd6);
         if (i == 9) chk("held_idle_gap", {31'd0, busy8}, 32'd0);
         if (i == 10) begin
            chk("held_accept_k10", {31'd0, busy8}, 32'd1);
            start8 = 1'b0;
         end
         if (i == 17) chk("held_diff_hold", {24'd0, diff8}, 32'd6);
         if (i == 18) begin
            chk("held_done2", {31'd0, done8}, 32'd1);
            chk("held_diff_1_1", {24'd0, diff8}, 32'd0);
         end
      end
      chk("held_done_count", ndone, 32'd2);
      chk("held_first_done", first_done, 32'd8);
      @(posedge clk); #1;

      // 5 - 10 wraps
      run8(8'd5, 8'd10, 1'b0, lat, bcnt);
      chk("diff_5_10", {24'd0, diff8}, 32'd251);
      chk("bo_5_10", {31'd0, bo8}, 32'd1);

      // Asynchronous reset on the 4th RUN cycle
      @(negedge clk);
      start8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("pre_rst_busy", {31'd0, busy8}, 32'd1);
      chk("pre_rst_diff_hold", {24'd0, diff8}, 32'd251);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy8}, 32'd0);
      chk("arst_done", {31'd0, done8}, 32'd0);
      chk("arst_diff", {24'd0, diff8}, 32'd0);
      chk("arst_borrow", {31'd0, bo8}, 32'd0);
      ndone = 0;
      repeat (3) begin @(posedge clk); #1; if (done8 === 1'b1) ndone++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #1; if (done8 === 1'b1) ndone++; end
      chk("arst_no_done", ndone, 32'd0);
      chk("arst_idle", {31'd0, busy8}, 32'd0);

      run8(8'd100, 8'd1, 1'b0, lat, bcnt);
      chk("diff_100_1", {24'd0, diff8}, 32'd99);
      chk("bo_100_1", {31'd0, bo8}, 32'd0);

      run8(8'hA5, 8'hA5, 1'b0, lat, bcnt);
      chk("diff_a5_a5", {24'd0, diff8}, 32'd0);
      chk("bo_a5_a5", {31'd0, bo8}, 32'd0);

`ifdef SUB_BORROW_IN_EN
      run8(8'd0, 8'd0, 1'b1, lat, bcnt);
      chk("diff_0_0_bin", {24'd0, diff8}, 32'd255);
      chk("bo_0_0_bin", {31'd0, bo8}, 32'd1);
      run8(8'd10, 8'd3, 1'b1, lat, bcnt);
      chk("diff_10_3_bin", {24'd0, diff8}, 32'd6);
      chk("bo_10_3_bin", {31'd0, bo8}, 32'd0);
`endif

      // Exhaustive WIDTH=4
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            logic [3:0] exp_d;
            logic       exp_b;
            int         w;
            exp_d = 4'(i - j);
            exp_b = (i < j);
            @(negedge clk);
            start4 = 1'b1; a4 = 4'(i); b4 = 4'(j); bin4 = 1'b0;
            @(posedge clk); #1;
            start4 = 1'b0;
            w = 0;
            while (done4 !== 1'b1 && w < 12) begin
               @(posedge clk); #1;
               w++;
            end
            chk("w4_latency", w, 32'd4);
            chk("w4_diff", {28'd0, diff4}, {28'd0, exp_d});
            chk("w4_borrow", {31'd0, bo4}, {31'd0, exp_b});
            @(posedge clk); #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
